sample_packer: RTL and testbench
================================

# sample_packer

Downstream of the ADC/test-pattern data generator: takes its 10-bit sample each clock while capture is enabled, packs every 8 samples into 5 16-bit words (dense, no padding) and buffers them in a small FIFO. The FIFO drains over a valid/ready handshake to the USB bus interface. A sticky overflow flag is set when packed words are lost because the buffer is full.

## Interface
- FIFO_DEPTH, 16: output FIFO depth in 16-bit words; power of two, ≥ 4.
- clock  in  1  sample clock; all logic on its rising edge.
- nReset  in  1  asynchronous, active-low reset.
- collectData  in  1  capture enable; a sample is accepted on every rising edge where it is high.
- dataIn  in  10  sample from the data generator.
- outReady  in  1  consumer can take a word this cycle.
- outData  out  16  FIFO head word; don't-care while outValid is low.
- outValid  out  1  FIFO non-empty.
- bufferOverflow  out  1  sticky: at least one packed word was dropped.
- fifoLevel  out  $clog2(FIFO_DEPTH)+1  current number of words held.

## Operation
- Bit stream: sample k of a group (k = 0..7) occupies stream bits [10k+9:10k]. Word j (j = 0..4) = stream bits [16j+15:16j]. LSB first in both.
- Word completion: word 0 by sample 1, word 1 by sample 3, word 2 by sample 4, word 3 by sample 6, word 4 by sample 7. At most one word completes per sample; samples 0, 2 and 5 complete none.
- Group counter 0..7 wraps to 0 after sample 7. Residual bits from a sample spanning two words are held in the packer.
- Rising edge of collectData (low last cycle, high now): group counter and residual bits clear, and bufferOverflow clears. The sample on that edge is sample 0.
- collectData low: no samples accepted, and any partial group is discarded. The next capture starts a fresh group. FIFO contents remain and keep draining.
- Push: a completed word is written on the same edge that captures its completing sample. If the FIFO is full at that edge and no pop occurs on it, the word is dropped and bufferOverflow is set. Packing continues in sequence; later words are not realigned.
- Pop: occurs on an edge where outValid and outReady are both high.
- Simultaneous push and pop when full: both succeed and the level is unchanged. Push into an empty FIFO with no pop: level 0 → 1.
- Pointers wrap modulo FIFO_DEPTH. fifoLevel equals pushes minus pops and never exceeds FIFO_DEPTH.

## Timing
- Reset values: outValid 0, outData 0, bufferOverflow 0, fifoLevel 0. Group counter, residual bits and FIFO pointers are all 0.
- Reset mid-operation clears all state immediately (asynchronous). After release, nothing is accepted until the first edge with collectData high, which counts as a rising edge.
- Latency: a word pushed at edge N appears as outValid high with outData valid after edge N if the FIFO was empty. outData and outValid are registered; no combinational path from outReady to outData or outValid.
- outData holds stable while outValid is high and outReady is low.
- Throughput: 5 words per 8 samples. With outReady tied high the FIFO never exceeds 1 word.
- bufferOverflow rises the cycle after the dropping edge. It stays high until the next collectData rising edge or reset.

## Test plan
- Ramp group: collectData high for 8 cycles, dataIn 0,1,...,7, outReady high. Required output words: 0x0400, 0xC020, 0x0400, 0x6014, 0x01C0. Each appears one cycle after sample 1, 3, 4, 6 and 7 respectively.
- All-ones: dataIn 0x3FF for 16 samples gives 10 words of 0xFFFF. All-zeros gives 10 words of 0x0000.
- Backpressure: outReady low, stream ramp samples 0... fifoLevel reaches 16 on the 16th word with bufferOverflow still 0. The 17th word is dropped and bufferOverflow goes high. Raising outReady then drains exactly 16 words, matching words 0–15 of the expected stream.
- Partial group: collectData high for 5 samples, low for 3, high again with a fresh ramp 0..7. Required: 3 words from the partial group, then 0x0400, 0xC020, 0x0400, 0x6014, 0x01C0. bufferOverflow clears on the re-enable edge.
- Full plus simultaneous pop: FIFO at 16, outReady high on the same edge as a push. Required: level stays 16, no overflow, order preserved.
- Reset mid-group: nReset low after sample 3. Required: outputs return to reset values at once, and the next capture's first word is built from samples 0–1 of the new stream.

Source files
------------

// File: rtl/sample_packer.sv
// sample_packer: packs 10-bit samples densely (8 samples -> 5 words) into 16-bit words
// and buffers them in a FIFO drained over a valid/ready handshake.
module sample_packer #(
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          nReset,
   input  logic                          collectData,
   input  logic [9:0]                    dataIn,
   input  logic                          outReady,
   output logic [15:0]                   outData,
   output logic                          outValid,
   output logic                          bufferOverflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);
   localparam int AW = $clog2(FIFO_DEPTH);
   logic [2:0] k;
   logic [3:0] nres;
   logic [13:0] res, res_n;
   logic [23:0] acc;
   logic done, prev, push, pop, full;
   logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
   logic [AW:0] level_n;
   logic [15:0] mem [FIFO_DEPTH];
   // Residual bit count before sample k is (10*k) mod 16.
   always_comb begin
      nres = {k[0], 3'b000} + {k, 1'b0};
      acc = ({14'b0, dataIn} << nres) | {10'b0, res};
      done = collectData && nres >= 4'd6;
      res_n = done ? {6'b0, acc[23:16]} : acc[13:0];
      full = fifoLevel[AW];
      pop = outValid && outReady;
      push = done && (!full || pop);
      rd_n = rd_ptr + AW'(pop);
      level_n = fifoLevel + (AW+1)'(push) - (AW+1)'(pop);
   end
   always_ff @(posedge clock or negedge nReset)
      if (!nReset) begin
         k <= '0;
         res <= '0;
         prev <= 1'b0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         fifoLevel <= '0;
         outValid <= 1'b0;
         outData <= '0;
         bufferOverflow <= 1'b0;
      end else begin
         prev <= collectData;
         k <= collectData ? k + 3'd1 : 3'd0;
         res <= collectData ? res_n : 14'd0;
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_n;
         fifoLevel <= level_n;
         outValid <= |level_n;
         // A word written into an otherwise empty FIFO bypasses the memory to the head register.
         outData <= (fifoLevel == (AW+1)'(pop) && push) ? acc[15:0] : mem[rd_n];
         bufferOverflow <= (done && !push) ? 1'b1 : (collectData && !prev) ? 1'b0 : bufferOverflow;
      end
   always_ff @(posedge clock)
      if (push) mem[wr_ptr] <= acc[15:0];
endmodule

// File: tb/tb_sample_packer.sv
// tb_sample_packer: table-driven and scoreboard checks of sample_packer.
module tb_sample_packer;
   logic clock = 1'b0, nReset = 1'b0, collectData = 1'b0, outReady = 1'b0;
   logic [9:0] dataIn = '0;
   logic [15:0] outData;
   logic outValid, bufferOverflow;
   logic [4:0] fifoLevel;

   sample_packer #(.FIFO_DEPTH(16)) dut (
      .clock(clock), .nReset(nReset), .collectData(collectData), .dataIn(dataIn),
      .outReady(outReady), .outData(outData), .outValid(outValid),
      .bufferOverflow(bufferOverflow), .fifoLevel(fifoLevel)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit c;
      logic [9:0] d;
      bit ev;
      logic [15:0] ed;
   } vec_t;

   int checks = 0, errors = 0, npop = 0, mlvl = 0;
   bit movf = 0, mprev = 0;
   bit sb[$];
   logic [15:0] expq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Checks current outputs against the model, advances the model over the next edge, then steps.
   task automatic cyc(input bit c, input logic [9:0] d, input bit r);
      bit pop, push, done;
      logic [15:0] w = '0;
      collectData = c;
      dataIn = d;
      outReady = r;
      chk("sb_valid", outValid, mlvl > 0);
      chk("sb_level", fifoLevel, mlvl);
      chk("sb_ovf", bufferOverflow, movf);
      pop = mlvl > 0 && r;
      if (pop) begin
         npop++;
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_word: got %0h expected nothing queued", outData);
         end else chk("sb_word", outData, expq.pop_front());
      end
      done = 0;
      if (!c) sb.delete();
      else begin
         for (int i = 0; i < 10; i++) sb.push_back(d[i]);
         if (sb.size() >= 16) begin
            for (int i = 0; i < 16; i++) w[i] = sb.pop_front();
            done = 1;
         end
      end
      push = done && (mlvl < 16 || pop);
      if (push) expq.push_back(w);
      if (done && !push) movf = 1;
      else if (c && !mprev) movf = 0;
      mlvl += int'(push) - int'(pop);
      mprev = c;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, 10'd0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[9];
      logic [19:0] pair;
      tbl[0] = '{1, 10'd0, 0, 16'h0000};
      tbl[1] = '{1, 10'd1, 1, 16'h0400};
      tbl[2] = '{1, 10'd2, 0, 16'h0000};
      tbl[3] = '{1, 10'd3, 1, 16'hC020};
      tbl[4] = '{1, 10'd4, 1, 16'h0400};
      tbl[5] = '{1, 10'd5, 0, 16'h0000};
      tbl[6] = '{1, 10'd6, 1, 16'h6014};
      tbl[7] = '{1, 10'd7, 1, 16'h01C0};
      tbl[8] = '{0, 10'd0, 0, 16'h0000};
      #12;
      chk("rst_valid", outValid, 0);
      chk("rst_data", outData, 0);
      chk("rst_ovf", bufferOverflow, 0);
      chk("rst_level", fifoLevel, 0);
      nReset = 1'b1;
      @(posedge clock);
      #1;
      // Ramp group with outReady high
      foreach (tbl[i]) begin
         cyc(tbl[i].c, tbl[i].d, 1);
         chk("tbl_valid", outValid, tbl[i].ev);
         if (tbl[i].ev) chk("tbl_data", outData, tbl[i].ed);
         chk("tbl_tput", fifoLevel <= 5'd1, 1);
      end
      idle(2);
      // All ones, then all zeros
      npop = 0;
      for (int i = 0; i < 16; i++) cyc(1, 10'h3FF, 1);
      idle(3);
      chk("ones_words", npop, 10);
      npop = 0;
      for (int i = 0; i < 16; i++) cyc(1, 10'h000, 1);
      idle(3);
      chk("zeros_words", npop, 10);
      // Backpressure: 16 words fill, 17th dropped
      for (int i = 0; i < 28; i++) begin
         cyc(1, 10'(i), 0);
         if (i == 25) begin
            chk("bp_level16", fifoLevel, 16);
            chk("bp_ovf_low", bufferOverflow, 0);
         end
         if (i == 27) chk("bp_ovf_high", bufferOverflow, 1);
      end
      npop = 0;
      idle(20);
      chk("bp_drained", npop, 16);
      chk("bp_empty", expq.size(), 0);
      // Partial group then fresh ramp; overflow clears on re-enable
      chk("pt_ovf_pre", bufferOverflow, 1);
      npop = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1, 10'(i), 1);
         if (i == 0) chk("pt_ovf_clear", bufferOverflow, 0);
      end
      idle(3);
      for (int i = 0; i < 8; i++) cyc(1, 10'(i), 1);
      idle(4);
      chk("pt_words", npop, 8);
      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 27; i++) cyc(1, 10'(i + 40), 0);
      chk("fp_level_full", fifoLevel, 16);
      cyc(1, 10'd67, 1);
      chk("fp_level_kept", fifoLevel, 16);
      chk("fp_no_ovf", bufferOverflow, 0);
      idle(20);
      chk("fp_empty", expq.size(), 0);
      // Reset mid-group
      for (int i = 0; i < 4; i++) cyc(1, 10'(i + 9), 0);
      #2;
      nReset = 1'b0;
      collectData = 1'b0;
      #1;
      chk("mr_valid", outValid, 0);
      chk("mr_data", outData, 0);
      chk("mr_ovf", bufferOverflow, 0);
      chk("mr_level", fifoLevel, 0);
      sb.delete();
      expq.delete();
      mlvl = 0;
      movf = 0;
      mprev = 0;
      @(negedge clock);
      nReset = 1'b1;
      @(posedge clock);
      #1;
      pair = {10'd101, 10'd100};
      for (int i = 0; i < 8; i++) begin
         cyc(1, 10'(100 + i), 1);
         if (i == 1) chk("mr_first_word", outData, pair[15:0]);
      end
      idle(4);
      chk("end_empty", expq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
